rot_arbiter: RTL and testbench

Shares one 8-bit left-rotate datapath among NUM_REQ requesters. Each requester presents an operand and a rotate amount with a valid/ready handshake. The arbiter grants one request per cycle, rotates the operand, and holds the result in a single-entry output register tagged with the requester index. It sits between the bit-manipulation clients and the downstream consumer, and replaces per-client rotator copies.

---
 rtl/rot_pkg.sv | 18 +
 rtl/rot_unit.sv | 12 +
 rtl/rot_arbiter.sv | 114 +++++++++++
 tb/tb_rot_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/rot_pkg.sv
// Shared types and the rotate-left helper for the rot_arbiter datapath.
// The same rotl function is used by the RTL rotate unit and by the bench model.
package rot_pkg;

    localparam int DATA_W  = 8;
    localparam int SHIFT_W = 3;

    typedef logic [DATA_W-1:0]  rot_data_t;
    typedef logic [SHIFT_W-1:0] rot_shift_t;

    // Left-rotate: concatenate the byte with itself, shift, keep the upper copy.
    function automatic rot_data_t rotl(input rot_data_t d, input rot_shift_t k);
        logic [2*DATA_W-1:0] dbl;
        dbl = {d, d} << k;
        return dbl[2*DATA_W-1:DATA_W];
    endfunction

endpackage

// File: rtl/rot_unit.sv
// Purely combinational 8-bit left-rotate; one copy sits behind the grant mux.
module rot_unit
    import rot_pkg::*;
(
    input  logic [DATA_W-1:0]  din,
    input  logic [SHIFT_W-1:0] shift,
    output logic [DATA_W-1:0]  dout
);

    assign dout = rotl(din, shift);

endmodule

// File: rtl/rot_arbiter.sv
// Shares one left-rotate datapath among NUM_REQ valid/ready requesters.
// A single-entry result register holds the rotated operand and winner index.
// Build option: define ROT_ARB_RR_EN for round-robin arbitration; without it
// the lowest asserted requester index always wins (fixed priority).
module rot_arbiter
    import rot_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    input  logic [NUM_REQ*SHIFT_W-1:0] req_shift,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [DATA_W-1:0]          res_data,
    output logic [ID_W-1:0]            res_id
);

    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;
    logic [ID_W-1:0]   id_p1;

    logic               slot_free_p0;
    logic               gnt_any_p0;
    logic [ID_W-1:0]    gnt_id_p0;
    logic [DATA_W-1:0]  sel_data_p0;
    logic [SHIFT_W-1:0] sel_shift_p0;
    logic [DATA_W-1:0]  rot_p0;

    // ---- stage p0: grant, operand mux, rotate ----
    assign slot_free_p0 = !vld_p1 || res_ready;

`ifdef ROT_ARB_RR_EN
    logic [ID_W-1:0] last_grant;

    // Round-robin: scan from the requester after the previous winner, wrapping.
    always_comb begin
        gnt_any_p0 = 1'b0;
        gnt_id_p0  = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            if (!gnt_any_p0 && req_valid[(int'(last_grant) + off) % NUM_REQ]) begin
                gnt_any_p0 = 1'b1;
                gnt_id_p0  = ID_W'((int'(last_grant) + off) % NUM_REQ);
            end
        end
        if (rst || !slot_free_p0) begin
            gnt_any_p0 = 1'b0;
            gnt_id_p0  = '0;
        end
    end

    // Remember the winner of each transfer; reset favours requester 0 next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= ID_W'(NUM_REQ - 1);
        end else if (gnt_any_p0) begin
            last_grant <= gnt_id_p0;
        end
    end
`else
    // Fixed priority: the lowest asserted index wins (descending scan, last hit kept).
    always_comb begin
        gnt_any_p0 = 1'b0;
        gnt_id_p0  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                gnt_any_p0 = 1'b1;
                gnt_id_p0  = ID_W'(i);
            end
        end
        if (rst || !slot_free_p0) begin
            gnt_any_p0 = 1'b0;
            gnt_id_p0  = '0;
        end
    end
`endif

    // Grant is derived from valids, pointer and slot state only, never from data.
    assign req_ready = gnt_any_p0 ? (NUM_REQ'(1) << gnt_id_p0) : '0;

    assign sel_data_p0  = req_data[int'(gnt_id_p0)*DATA_W +: DATA_W];
    assign sel_shift_p0 = req_shift[int'(gnt_id_p0)*SHIFT_W +: SHIFT_W];

    rot_unit u_rot (
        .din   (sel_data_p0),
        .shift (sel_shift_p0),
        .dout  (rot_p0)
    );

    // ---- stage p1: single-entry result register ----
    // Load on transfer (overwrite allowed while draining), clear on a bare drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            id_p1   <= '0;
        end else if (gnt_any_p0) begin
            vld_p1  <= 1'b1;
            data_p1 <= rot_p0;
            id_p1   <= gnt_id_p0;
        end else if (res_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign res_valid = vld_p1;
    assign res_data  = data_p1;
    assign res_id    = id_p1;

endmodule

// File: tb/tb_rot_arbiter.sv
// Self-checking bench for rot_arbiter: table-driven rotate vectors, a one-entry
// scoreboard fed at grant time, and hand-written backpressure/reset/contention runs.
module tb_rot_arbiter;
    import rot_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ*3-1:0] req_shift;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 res_valid;
    logic                 res_ready;
    logic [7:0]           res_data;
    logic [ID_W-1:0]      res_id;

    rot_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_shift (req_shift),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]      data;
        logic [ID_W-1:0] id;
    } exp_t;

    typedef struct {
        int         who;
        logic [7:0] d;
        logic [2:0] s;
        logic [7:0] exp_d;
    } vec_t;

    exp_t            q[$];
    logic            m_valid;
    logic [7:0]      m_data;
    logic [ID_W-1:0] m_id;
    logic [ID_W-1:0] m_lg;
    int              checks = 0;
    int              errors = 0;
    int              last_id;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NUM_REQ-1:0] model_grant(input logic [NUM_REQ-1:0] v,
                                                       input logic [ID_W-1:0] lg,
                                                       input logic free);
        logic [NUM_REQ-1:0] g;
        g = '0;
        if (free) begin
`ifdef ROT_ARB_RR_EN
            for (int o = NUM_REQ; o >= 1; o--)
                if (v[(int'(lg) + o) % NUM_REQ]) g = NUM_REQ'(1) << ((int'(lg) + o) % NUM_REQ);
`else
            for (int i = NUM_REQ - 1; i >= 0; i--)
                if (v[i]) g = NUM_REQ'(1) << i;
`endif
        end
        return g;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_id    = '0;
        m_lg    = ID_W'(NUM_REQ - 1);
        q.delete();
    endtask

    // One clock: check grant at negedge, queue the expected result, check after edge.
    task automatic step();
        logic [NUM_REQ-1:0] g;
        exp_t               e;
        int                 id;
        @(negedge clk);
        g = model_grant(req_valid, m_lg, !m_valid || res_ready);
        chk("req_ready", req_ready, g);
        id = -1;
        for (int i = 0; i < NUM_REQ; i++) if (g[i]) id = i;
        if (id >= 0) begin
            e.data = rotl(req_data[id*8 +: 8], req_shift[id*3 +: 3]);
            e.id   = ID_W'(id);
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (id >= 0) begin
            e       = q.pop_front();
            m_valid = 1'b1;
            m_data  = e.data;
            m_id    = e.id;
            m_lg    = e.id;
        end else if (m_valid && res_ready) begin
            m_valid = 1'b0;
        end
        last_id = id;
        chk("res_valid", res_valid, m_valid);
        if (m_valid) begin
            chk("res_data", res_data, m_data);
            chk("res_id", res_id, m_id);
        end
    endtask

    vec_t       tbl[6];
    logic [7:0] held_d;
    logic [1:0] held_id;
    int         exp_seq[6];

    initial begin
        tbl[0] = '{0, 8'hA5, 3'd1, 8'h4B};
        tbl[1] = '{2, 8'h81, 3'd7, 8'hC0};
        tbl[2] = '{2, 8'h0F, 3'd4, 8'hF0};
        tbl[3] = '{2, 8'h3C, 3'd0, 8'h3C};
        tbl[4] = '{3, 8'h01, 3'd3, 8'h08};
        tbl[5] = '{1, 8'h80, 3'd1, 8'h01};

        // Reset state, with all requests raised to show no grant under reset
        rst       = 1'b1;
        req_valid = '1;
        req_data  = '0;
        req_shift = '0;
        res_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_req_ready", req_ready, 0);
        req_valid = '0;
        rst       = 1'b0;

        // Table-driven rotate vectors, one transfer each, then a drain
        for (int t = 0; t < 6; t++) begin
            req_data  = '0;
            req_shift = '0;
            req_valid = NUM_REQ'(1) << tbl[t].who;
            req_data[tbl[t].who*8 +: 8]  = tbl[t].d;
            req_shift[tbl[t].who*3 +: 3] = tbl[t].s;
            step();
            chk("vec_data", res_data, tbl[t].exp_d);
            chk("vec_id", res_id, tbl[t].who);
            req_valid = '0;
            step();
        end

        // Backpressure: hold a result, all requests valid, no grant for 5 cycles
        req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        req_shift = {3'd3, 3'd2, 3'd1, 3'd0};
        req_valid = 4'b0010;
        step();
        held_d    = res_data;
        held_id   = res_id;
        res_ready = 1'b0;
        req_valid = '1;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("bp_hold_data", res_data, held_d);
            chk("bp_hold_id", res_id, held_id);
        end
        res_ready = 1'b1;
        step();
`ifdef ROT_ARB_RR_EN
        chk("bp_release_id", res_id, 2);
`else
        chk("bp_release_id", res_id, 0);
`endif

        // Reset mid-operation with a held result: clears without a clock
        res_ready = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", res_valid, 0);
        chk("mid_rst_data", res_data, 0);
        chk("mid_rst_ready", req_ready, 0);
        model_reset();
        @(posedge clk);
        #1;
        chk("mid_rst_ready_hold", req_ready, 0);
        chk("mid_rst_valid_hold", res_valid, 0);
        rst       = 1'b0;
        res_ready = 1'b1;

        // Contention: all four requesters continuously valid
`ifdef ROT_ARB_RR_EN
        exp_seq = '{0, 1, 2, 3, 0, 1};
`else
        exp_seq = '{0, 0, 0, 0, 0, 0};
`endif
        for (int c = 0; c < 6; c++) begin
            step();
            chk("cont_valid", res_valid, 1);
            chk("cont_id", res_id, exp_seq[c]);
        end
        req_valid = 4'b1110;
        step();
`ifdef ROT_ARB_RR_EN
        chk("drop0_id", res_id, 2);
`else
        chk("drop0_id", res_id, 1);
`endif
        chk("drop0_data", res_data, rotl(req_data[last_id*8 +: 8], req_shift[last_id*3 +: 3]));

        // Drain back to idle
        req_valid = '0;
        step();
        chk("idle_valid", res_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
